alu_rs: RTL and testbench
=========================

Name: alu_rs

Overview:
- Reservation station directly upstream of the ALU.
- Holds up to RS_SIZE decoded ALU/branch ops, captures missing operands from the ALU and LSB result buses, and dispatches one ready op per cycle as registered outputs.
- Sits between the decoder/issue stage and the ALU; its outputs drive the ALU calculate-request pins one-to-one.

Parameters:
- ROB_WIDTH, 4, width of ROB tags.
- RS_WIDTH, 3, log2 of entry count; RS_SIZE = 2**RS_WIDTH = 8 entries.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  ready; when low, all state frozen
- clear_signal  input  1  misprediction flush
- issue_valid  input  1  new op offered this cycle
- issue_opcode  input  4  ALU opcode (NOP..JALR encoding, 0..15)
- issue_qj_busy  input  1  1 = lhs not yet available; wait on issue_qj
- issue_vj  input  32  lhs value when available
- issue_qj  input  ROB_WIDTH  producer tag for lhs
- issue_qk_busy  input  1  1 = rhs not yet available; wait on issue_qk
- issue_vk  input  32  rhs value when available
- issue_qk  input  ROB_WIDTH  producer tag for rhs
- issue_tag  input  ROB_WIDTH  destination ROB tag
- rs_full  output  1  all entries busy; combinational from busy bits
- alu_done  input  1  ALU result broadcast valid
- alu_value  input  32  ALU result value
- alu_tag  input  ROB_WIDTH  ALU result tag
- lsb_done  input  1  LSB result broadcast valid
- lsb_value  input  32  LSB result value
- lsb_tag  input  ROB_WIDTH  LSB result tag
- cal_signal  output  1  dispatch valid, one cycle per op
- opcode  output  4  dispatched opcode
- lhs  output  32  dispatched lhs
- rhs  output  32  dispatched rhs
- tag  output  ROB_WIDTH  dispatched ROB tag

Behaviour:
- Reset (rst_in=0, async): all entries not busy; cal_signal, opcode, lhs, rhs, tag = 0. rs_full = 0.
- All non-reset updates occur on posedge clk_in only when rdy_in=1. With rdy_in=0, entries and outputs hold, including cal_signal.
- Entry fields: busy, op, vj, vk, qj_busy, qk_busy, qj, qk, dest.
- Issue:
  - Accepted when issue_valid=1 and not rs_full. Writes the lowest-index free entry.
  - issue_valid while rs_full is ignored; the op is lost and the issuer must not do it.
- Issue bypass: for each operand with *_busy=1, if alu_done and alu_tag match in the same cycle, store alu_value and mark ready. Likewise for lsb. ALU match takes precedence if both match.
- Wakeup: each cycle, every busy entry with qj_busy and qj==alu_tag (alu_done) captures alu_value into vj and clears qj_busy. Same for the lsb bus, and same for k.
- Dispatch selection: among entries busy with qj_busy=0 and qk_busy=0 as registered at the start of the cycle, pick the lowest index. On that edge:
  - cal_signal<=1; opcode, lhs, rhs, tag <= entry fields.
  - The entry's busy bit is cleared.
- If no entry is ready: cal_signal<=0. Other outputs hold their last values.
- Latency: an op issued fully ready at edge N dispatches at edge N+1 (cal_signal high in cycle after N+1 edge). An op woken at edge N dispatches at edge N+1 at the earliest.
- Same-edge issue into a freed slot: not allowed. The freed slot becomes available from the next cycle. rs_full reflects pre-edge busy bits.
- Clear: clear_signal=1 with rdy_in=1 clears all busy bits and cal_signal<=0. Clear wins over simultaneous issue, wakeup and dispatch. Output data registers may hold.
- No entry is ever dispatched twice. cal_signal is never high two cycles for the same entry.

Test Plan:
- Reset then issue ADD, vj=5, vk=7, both ready, tag=3 -> one cycle later: cal_signal=1, opcode=4, lhs=5, rhs=7, tag=3. Next cycle cal_signal=0.
- Issue SUB with qj_busy=1, qj=2, vk=1 -> no dispatch. Then alu_done=1, alu_tag=2, alu_value=10 -> next edge captured, following edge dispatches lhs=10, rhs=1.
- Issue with qk_busy=1, qk=6 in the same cycle that lsb_done=1, lsb_tag=6, lsb_value=0x80000000 -> dispatch next edge with rhs=0x80000000 (bypass).
- Issue 8 ops all waiting on tag 9 -> rs_full=1, a 9th issue is ignored. Broadcast tag 9 -> dispatches in index order 0..7 on 8 consecutive cycles, then rs_full=0.
- With 3 entries waiting, assert clear_signal together with alu_done matching them -> no dispatch afterward, rs_full=0, cal_signal=0.
- Hold rdy_in=0 for 5 cycles with a ready entry -> no change. Raise rdy_in -> dispatch next edge. Pull rst_in low mid-cycle -> outputs zero immediately.

Source files
------------

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - reservation station feeding the ALU
// Purpose: holds up to 2**RS_WIDTH decoded ALU/branch ops, captures missing
//          operands from the ALU and LSB result buses, and dispatches the
//          lowest-index ready op each cycle on registered outputs.
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global stall when low)
//   clear_signal                - flush all entries
//   issue_*                     - op offered by the issue stage
//   rs_full                     - all entries busy (combinational)
//   alu_done/value/tag          - ALU result broadcast
//   lsb_done/value/tag          - LSB result broadcast
//   cal_signal/opcode/lhs/rhs/tag - dispatch to the ALU
module alu_rs #(
    parameter int ROB_WIDTH = 4,
    parameter int RS_WIDTH  = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_signal,
    input  logic                 issue_valid,
    input  logic [3:0]           issue_opcode,
    input  logic                 issue_qj_busy,
    input  logic [31:0]          issue_vj,
    input  logic [ROB_WIDTH-1:0] issue_qj,
    input  logic                 issue_qk_busy,
    input  logic [31:0]          issue_vk,
    input  logic [ROB_WIDTH-1:0] issue_qk,
    input  logic [ROB_WIDTH-1:0] issue_tag,
    output logic                 rs_full,
    input  logic                 alu_done,
    input  logic [31:0]          alu_value,
    input  logic [ROB_WIDTH-1:0] alu_tag,
    input  logic                 lsb_done,
    input  logic [31:0]          lsb_value,
    input  logic [ROB_WIDTH-1:0] lsb_tag,
    output logic                 cal_signal,
    output logic [3:0]           opcode,
    output logic [31:0]          lhs,
    output logic [31:0]          rhs,
    output logic [ROB_WIDTH-1:0] tag
);

    localparam int RS_SIZE = 1 << RS_WIDTH;

    logic [RS_SIZE-1:0]   busy;
    logic [RS_SIZE-1:0]   qj_busy;
    logic [RS_SIZE-1:0]   qk_busy;
    logic [3:0]           op   [RS_SIZE];
    logic [31:0]          vj   [RS_SIZE];
    logic [31:0]          vk   [RS_SIZE];
    logic [ROB_WIDTH-1:0] qj   [RS_SIZE];
    logic [ROB_WIDTH-1:0] qk   [RS_SIZE];
    logic [ROB_WIDTH-1:0] dest [RS_SIZE];

    logic [RS_SIZE-1:0]  ready;
    logic [RS_WIDTH-1:0] free_idx;
    logic [RS_WIDTH-1:0] disp_idx;
    logic                disp_any;

    // Issue-time operand resolution, including same-cycle bypass from the
    // result buses (ALU wins when both buses carry the wanted tag).
    logic        new_qj_busy;
    logic        new_qk_busy;
    logic [31:0] new_vj;
    logic [31:0] new_vk;

    assign rs_full = &busy;
    assign ready   = busy & ~qj_busy & ~qk_busy;
    assign disp_any = |ready;

    // Lowest-index free and ready entries; descending scan so the last hit
    // (the lowest index) is the one kept.
    always_comb begin
        free_idx = '0;
        disp_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = i[RS_WIDTH-1:0];
            if (ready[i]) disp_idx = i[RS_WIDTH-1:0];
        end
    end

    always_comb begin
        new_qj_busy = issue_qj_busy;
        new_vj      = issue_vj;
        if (issue_qj_busy) begin
            if (alu_done && alu_tag == issue_qj) begin
                new_qj_busy = 1'b0;
                new_vj      = alu_value;
            end else if (lsb_done && lsb_tag == issue_qj) begin
                new_qj_busy = 1'b0;
                new_vj      = lsb_value;
            end
        end
        new_qk_busy = issue_qk_busy;
        new_vk      = issue_vk;
        if (issue_qk_busy) begin
            if (alu_done && alu_tag == issue_qk) begin
                new_qk_busy = 1'b0;
                new_vk      = alu_value;
            end else if (lsb_done && lsb_tag == issue_qk) begin
                new_qk_busy = 1'b0;
                new_vk      = lsb_value;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy       <= '0;
            qj_busy    <= '0;
            qk_busy    <= '0;
            cal_signal <= 1'b0;
            opcode     <= '0;
            lhs        <= '0;
            rhs        <= '0;
            tag        <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op[i]   <= '0;
                vj[i]   <= '0;
                vk[i]   <= '0;
                qj[i]   <= '0;
                qk[i]   <= '0;
                dest[i] <= '0;
            end
        end else if (rdy_in) begin
            if (clear_signal) begin
                busy       <= '0;
                cal_signal <= 1'b0;
            end else begin
                // Wakeup: a free slot may also match, but its fields are
                // either don't-care or overwritten by the issue below.
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (qj_busy[i]) begin
                        if (alu_done && alu_tag == qj[i]) begin
                            qj_busy[i] <= 1'b0;
                            vj[i]      <= alu_value;
                        end else if (lsb_done && lsb_tag == qj[i]) begin
                            qj_busy[i] <= 1'b0;
                            vj[i]      <= lsb_value;
                        end
                    end
                    if (qk_busy[i]) begin
                        if (alu_done && alu_tag == qk[i]) begin
                            qk_busy[i] <= 1'b0;
                            vk[i]      <= alu_value;
                        end else if (lsb_done && lsb_tag == qk[i]) begin
                            qk_busy[i] <= 1'b0;
                            vk[i]      <= lsb_value;
                        end
                    end
                end

                if (disp_any) begin
                    cal_signal     <= 1'b1;
                    opcode         <= op[disp_idx];
                    lhs            <= vj[disp_idx];
                    rhs            <= vk[disp_idx];
                    tag            <= dest[disp_idx];
                    busy[disp_idx] <= 1'b0;
                end else begin
                    cal_signal <= 1'b0;
                end

                // free_idx is never the dispatched entry (that one is busy),
                // so a slot freed this edge is only reusable next cycle.
                if (issue_valid && !rs_full) begin
                    busy[free_idx]    <= 1'b1;
                    op[free_idx]      <= issue_opcode;
                    qj_busy[free_idx] <= new_qj_busy;
                    qk_busy[free_idx] <= new_qk_busy;
                    vj[free_idx]      <= new_vj;
                    vk[free_idx]      <= new_vk;
                    qj[free_idx]      <= issue_qj;
                    qk[free_idx]      <= issue_qk;
                    dest[free_idx]    <= issue_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - scoreboard bench for alu_rs
module tb_alu_rs;

    localparam int RW = 4;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          rdy_in = 1'b1;
    logic          clear_signal = 1'b0;
    logic          issue_valid = 1'b0;
    logic [3:0]    issue_opcode = '0;
    logic          issue_qj_busy = 1'b0;
    logic [31:0]   issue_vj = '0;
    logic [RW-1:0] issue_qj = '0;
    logic          issue_qk_busy = 1'b0;
    logic [31:0]   issue_vk = '0;
    logic [RW-1:0] issue_qk = '0;
    logic [RW-1:0] issue_tag = '0;
    logic          rs_full;
    logic          alu_done = 1'b0;
    logic [31:0]   alu_value = '0;
    logic [RW-1:0] alu_tag = '0;
    logic          lsb_done = 1'b0;
    logic [31:0]   lsb_value = '0;
    logic [RW-1:0] lsb_tag = '0;
    logic          cal_signal;
    logic [3:0]    opcode;
    logic [31:0]   lhs;
    logic [31:0]   rhs;
    logic [RW-1:0] tag;

    alu_rs #(.ROB_WIDTH(RW), .RS_WIDTH(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .clear_signal(clear_signal), .issue_valid(issue_valid),
        .issue_opcode(issue_opcode), .issue_qj_busy(issue_qj_busy),
        .issue_vj(issue_vj), .issue_qj(issue_qj),
        .issue_qk_busy(issue_qk_busy), .issue_vk(issue_vk),
        .issue_qk(issue_qk), .issue_tag(issue_tag), .rs_full(rs_full),
        .alu_done(alu_done), .alu_value(alu_value), .alu_tag(alu_tag),
        .lsb_done(lsb_done), .lsb_value(lsb_value), .lsb_tag(lsb_tag),
        .cal_signal(cal_signal), .opcode(opcode), .lhs(lhs), .rhs(rhs),
        .tag(tag)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [3:0]    op;
        logic [31:0]   l;
        logic [31:0]   r;
        logic [RW-1:0] t;
    } disp_t;

    disp_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    logic  rdy_q = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Remembers whether the last edge was an active (unstalled) one, so a
    // cal_signal held high through a stall is not counted as a new dispatch.
    always @(posedge clk_in) rdy_q = rdy_in;

    always @(negedge clk_in) begin
        if (rst_in && rdy_q && cal_signal) begin
            disp_t got;
            disp_t want;
            got = '{op: opcode, l: lhs, r: rhs, t: tag};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_dispatch: got op=%0d lhs=0x%0h rhs=0x%0h tag=%0d expected none",
                         opcode, lhs, rhs, tag);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    fails++;
                    $display("FAIL dispatch: got op=%0d lhs=0x%0h rhs=0x%0h tag=%0d expected op=%0d lhs=0x%0h rhs=0x%0h tag=%0d",
                             opcode, lhs, rhs, tag, want.op, want.l, want.r, want.t);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic jb, input logic [31:0] vj_v,
                         input logic [RW-1:0] qj_v, input logic kb, input logic [31:0] vk_v,
                         input logic [RW-1:0] qk_v, input logic [RW-1:0] t);
        issue_valid   = 1'b1;
        issue_opcode  = o;
        issue_qj_busy = jb;
        issue_vj      = vj_v;
        issue_qj      = qj_v;
        issue_qk_busy = kb;
        issue_vk      = vk_v;
        issue_qk      = qk_v;
        issue_tag     = t;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation bound reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        tick();
        tick();
        check("reset_cal", {31'd0, cal_signal}, 32'd0);
        check("reset_opcode", {28'd0, opcode}, 32'd0);
        check("reset_lhs", lhs, 32'd0);
        check("reset_rhs", rhs, 32'd0);
        check("reset_tag", {28'd0, tag}, 32'd0);
        check("reset_full", {31'd0, rs_full}, 32'd0);
        rst_in = 1'b1;
        tick();

        // Fully ready ADD: dispatch one edge after issue
        issue(4'd4, 1'b0, 32'd5, 4'd0, 1'b0, 32'd7, 4'd0, 4'd3);
        exp_q.push_back('{op: 4'd4, l: 32'd5, r: 32'd7, t: 4'd3});
        tick();
        issue_valid = 1'b0;
        check("add_not_yet", {31'd0, cal_signal}, 32'd0);
        tick();
        check("add_dispatch", {31'd0, cal_signal}, 32'd1);
        tick();
        check("add_one_cycle", {31'd0, cal_signal}, 32'd0);

        // SUB waiting on tag 2, woken by the ALU bus
        issue(4'd2, 1'b1, 32'd0, 4'd2, 1'b0, 32'd1, 4'd0, 4'd5);
        tick();
        issue_valid = 1'b0;
        tick();
        check("sub_waiting", {31'd0, cal_signal}, 32'd0);
        alu_done = 1'b1; alu_tag = 4'd2; alu_value = 32'd10;
        exp_q.push_back('{op: 4'd2, l: 32'd10, r: 32'd1, t: 4'd5});
        tick();
        alu_done = 1'b0;
        check("sub_capture_edge", {31'd0, cal_signal}, 32'd0);
        tick();
        check("sub_dispatch", {31'd0, cal_signal}, 32'd1);
        tick();

        // Issue-time bypass from the LSB bus
        issue(4'd1, 1'b0, 32'd3, 4'd0, 1'b1, 32'd0, 4'd6, 4'd7);
        lsb_done = 1'b1; lsb_tag = 4'd6; lsb_value = 32'h8000_0000;
        exp_q.push_back('{op: 4'd1, l: 32'd3, r: 32'h8000_0000, t: 4'd7});
        tick();
        issue_valid = 1'b0; lsb_done = 1'b0;
        tick();
        check("bypass_dispatch", {31'd0, cal_signal}, 32'd1);
        tick();

        // Fill all 8 entries waiting on tag 9; a 9th issue is dropped
        for (int i = 0; i < 8; i++) begin
            issue(4'(i + 5), 1'b1, 32'd0, 4'd9, 1'b0, 32'(100 + i), 4'd0, 4'(i));
            tick();
        end
        check("full_after_8", {31'd0, rs_full}, 32'd1);
        issue(4'd15, 1'b0, 32'd1, 4'd0, 1'b0, 32'd2, 4'd0, 4'd15);
        tick();
        issue_valid = 1'b0;
        check("full_hold", {31'd0, rs_full}, 32'd1);
        alu_done = 1'b1; alu_tag = 4'd9; alu_value = 32'h1234;
        for (int i = 0; i < 8; i++)
            exp_q.push_back('{op: 4'(i + 5), l: 32'h1234, r: 32'(100 + i), t: 4'(i)});
        tick();
        alu_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("drain_cal", {31'd0, cal_signal}, 32'd1);
        end
        check("drain_not_full", {31'd0, rs_full}, 32'd0);
        tick();
        check("drain_done", {31'd0, cal_signal}, 32'd0);

        // Clear beats a simultaneous matching wakeup
        for (int i = 0; i < 3; i++) begin
            issue(4'd6, 1'b1, 32'd0, 4'd11, 1'b0, 32'd9, 4'd0, 4'(i + 1));
            tick();
        end
        issue_valid = 1'b0;
        clear_signal = 1'b1;
        alu_done = 1'b1; alu_tag = 4'd11; alu_value = 32'd77;
        tick();
        clear_signal = 1'b0; alu_done = 1'b0;
        check("clear_full", {31'd0, rs_full}, 32'd0);
        check("clear_cal", {31'd0, cal_signal}, 32'd0);
        tick();
        tick();
        check("clear_no_dispatch", {31'd0, cal_signal}, 32'd0);

        // Stall: nothing moves while rdy_in is low
        issue(4'd3, 1'b0, 32'd20, 4'd0, 1'b0, 32'd30, 4'd0, 4'd4);
        tick();
        issue_valid = 1'b0;
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_no_dispatch", {31'd0, cal_signal}, 32'd0);
        end
        rdy_in = 1'b1;
        exp_q.push_back('{op: 4'd3, l: 32'd20, r: 32'd30, t: 4'd4});
        tick();
        check("stall_release", {31'd0, cal_signal}, 32'd1);
        rdy_in = 1'b0;
        tick();
        tick();
        check("stall_holds_cal", {31'd0, cal_signal}, 32'd1);
        rdy_in = 1'b1;
        tick();
        check("stall_cal_drop", {31'd0, cal_signal}, 32'd0);
        check("hold_opcode", {28'd0, opcode}, 32'd3);

        // Asynchronous reset mid-cycle
        #2;
        rst_in = 1'b0;
        #1;
        check("async_opcode", {28'd0, opcode}, 32'd0);
        check("async_lhs", lhs, 32'd0);
        check("async_rhs", rhs, 32'd0);
        check("async_tag", {28'd0, tag}, 32'd0);
        tick();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
